// File: rtl/concat_arb_pkg.sv
// Shared types and helpers for the concat_stream_arbiter block.
// Holds the FSM state encoding and a width helper that never returns zero.
package concat_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Index width for n items, kept at least 1 so a count of 1 still gets a real bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr_i, wrapping.
// gnt_any_o is low when no request is asserted; gnt_idx_o is then 0.
module rr_priority_pick #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SRC_W-1:0]   ptr_i,
    output logic [SRC_W-1:0]   gnt_idx_o,
    output logic               gnt_any_o
);

    int             idx;
    logic [SRC_W-1:0] sel;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves a latch.
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        idx       = 0;
        sel       = '0;
        // Walk from the farthest offset down so the nearest request above ptr_i wins.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = (int'(ptr_i) + i) % NUM_SRC;
            sel = idx[SRC_W-1:0];
            if (req_i[sel]) begin
                gnt_idx_o = sel;
                gnt_any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/concat_stream_arbiter.sv
// Grants one narrow-word source at a time for a full group of beats feeding a word concatenator,
// so each concatenated word comes from a single source; beats are tagged with their source index.
module concat_stream_arbiter
    import concat_arb_pkg::*;
#(
    parameter  int NUM_SRC         = 4,
    parameter  int DATA_WIDTH      = 8,
    parameter  int WORDS_PER_GROUP = 4,
    localparam int SRC_W           = width_of(NUM_SRC)
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          enable_i,
    input  logic [NUM_SRC-1:0]            src_mask_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
    input  logic [NUM_SRC-1:0]            src_valid_i,
    output logic [NUM_SRC-1:0]            src_ready_o,
    output logic [DATA_WIDTH-1:0]         cat_data_o,
    output logic                          cat_valid_o,
    output logic                          grp_last_o,
    output logic [SRC_W-1:0]              grp_src_o,
    output logic                          busy_o
);

    localparam int               CNT_W     = width_of(WORDS_PER_GROUP);
    localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_GROUP - 1);

    arb_state_e            state_q;
    logic [SRC_W-1:0]      grant_q;
    logic [SRC_W-1:0]      rr_q;
    logic [SRC_W-1:0]      rr_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] cat_data_q;
    logic                  cat_valid_q;
    logic                  grp_last_q;
    logic [SRC_W-1:0]      grp_src_q;

    logic [NUM_SRC-1:0]    req;
    logic [SRC_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  beat_ok;
    logic [DATA_WIDTH-1:0] grant_word;

    assign req        = src_valid_i & src_mask_i;
    assign beat_ok    = (state_q == BURST) && src_valid_i[grant_q];
    assign grant_word = src_data_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign rr_d       = (grant_q == LAST_SRC) ? '0 : grant_q + SRC_W'(1);

    rr_priority_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req_i     (req),
        .ptr_i     (rr_q),
        .gnt_idx_o (pick_idx),
        .gnt_any_o (pick_any)
    );

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            cat_data_q  <= '0;
            cat_valid_q <= 1'b0;
            grp_last_q  <= 1'b0;
            grp_src_q   <= '0;
        end else begin
            cat_valid_q <= 1'b0;
            grp_last_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable_i && pick_any) begin
                        state_q <= BURST;
                        grant_q <= pick_idx;
                        cnt_q   <= '0;
                    end
                end
                BURST: begin
                    // Data and source tag hold between beats; only valid/last pulse.
                    if (beat_ok) begin
                        cat_valid_q <= 1'b1;
                        cat_data_q  <= grant_word;
                        grp_src_q   <= grant_q;
                        if (cnt_q == LAST_BEAT) begin
                            grp_last_q <= 1'b1;
                            state_q    <= IDLE;
                            rr_q       <= rr_d;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        src_ready_o = '0;
        if (state_q == BURST) src_ready_o[grant_q] = 1'b1;
    end

    assign busy_o      = (state_q == BURST);
    assign cat_data_o  = cat_data_q;
    assign cat_valid_o = cat_valid_q;
    assign grp_last_o  = grp_last_q;
    assign grp_src_o   = grp_src_q;

endmodule

// File: tb/tb_concat_stream_arbiter.sv
// Directed bench for concat_stream_arbiter: counting source models, a beat monitor, and
// hand-derived group/source/data expectations including the 32-bit concatenated word.
module tb_concat_stream_arbiter;

    typedef struct {
        logic [7:0] data;
        logic [1:0] src;
        logic       last;
        int         cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [3:0]  mask;
    logic [3:0]  valid;
    logic [31:0] src_data;
    logic [3:0]  ready;
    logic [7:0]  cat_data;
    logic        cat_valid;
    logic        grp_last;
    logic [1:0]  grp_src;
    logic        busy;

    logic [7:0]  base [4];
    int          idx  [4];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          exp_grp [8];
    int          c0;
    beat_t       obs_q [$];

    concat_stream_arbiter #(
        .NUM_SRC         (4),
        .DATA_WIDTH      (8),
        .WORDS_PER_GROUP (4)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .enable_i    (enable),
        .src_mask_i  (mask),
        .src_data_i  (src_data),
        .src_valid_i (valid),
        .src_ready_o (ready),
        .cat_data_o  (cat_data),
        .cat_valid_o (cat_valid),
        .grp_last_o  (grp_last),
        .grp_src_o   (grp_src),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Each source offers base[k] + (number of its words accepted so far).
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!reset_n) idx[k] <= 0;
            else if (valid[k] && ready[k]) idx[k] <= idx[k] + 1;
        end
    end

    always_comb begin
        src_data = '0;
        for (int k = 0; k < 4; k++) src_data[k*8 +: 8] = base[k] + idx[k][7:0];
    end

    always @(negedge clk) begin
        beat_t b;
        if (cat_valid) begin
            b.data = cat_data;
            b.src  = grp_src;
            b.last = grp_last;
            b.cyc  = cyc;
            obs_q.push_back(b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        valid   = 4'b0000;
        enable  = 1'b1;
        mask    = 4'b1111;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        obs_q.delete();
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        for (int c = 0; c < budget && obs_q.size() < n; c++) begin
            @(posedge clk);
            #1;
        end
        check(tag, 32'(obs_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idx(input string tag, input int k, input int n, input int budget);
        for (int c = 0; c < budget && idx[k] < n; c++) begin
            @(posedge clk);
            #1;
        end
        check(tag, 32'(idx[k]), 32'(n));
    endtask

    // Groups of 4 beats from obs_q[first]: source exp_grp[g], sequential words, last on beat 3.
    task automatic check_groups(input string tag, input int first, input int ngroups, input bit contig);
        int          seen [4];
        int          s;
        int          j;
        beat_t       b;
        logic [7:0]  exp_d;
        logic [31:0] word;
        logic [31:0] exp_word;
        for (int k = 0; k < 4; k++) seen[k] = 0;
        check($sformatf("%s_count", tag), 32'(obs_q.size() >= first + ngroups * 4), 32'd1);
        if (obs_q.size() < first + ngroups * 4) return;
        for (int g = 0; g < ngroups; g++) begin
            s        = exp_grp[g];
            word     = '0;
            exp_word = '0;
            for (int i = 0; i < 4; i++) begin
                j     = first + g * 4 + i;
                b     = obs_q[j];
                exp_d = base[s] + 8'(seen[s]);
                seen[s]++;
                check($sformatf("%s_g%0d_b%0d_src", tag, g, i), 32'(b.src), 32'(s));
                check($sformatf("%s_g%0d_b%0d_data", tag, g, i), 32'(b.data), 32'(exp_d));
                check($sformatf("%s_g%0d_b%0d_last", tag, g, i), 32'(b.last), 32'(i == 3));
                if (contig && j > first)
                    check($sformatf("%s_g%0d_b%0d_gap", tag, g, i),
                          32'(b.cyc - obs_q[j-1].cyc), (i == 0) ? 32'd2 : 32'd1);
                word     = {b.data, word[31:8]};
                exp_word = {exp_d, exp_word[31:8]};
            end
            check($sformatf("%s_g%0d_word", tag, g), word, exp_word);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) base[k] = 8'(k * 64);

        // 1: reset held with every source requesting
        reset_n = 1'b0;
        enable  = 1'b1;
        mask    = 4'b1111;
        valid   = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst%0d_ready", c), 32'(ready), 32'd0);
            check($sformatf("rst%0d_flags", c), 32'({cat_valid, grp_last, busy}), 32'd0);
            check($sformatf("rst%0d_data", c), 32'(cat_data), 32'd0);
            check($sformatf("rst%0d_src", c), 32'(grp_src), 32'd0);
        end

        // 2: single source 2 streaming 0x10..0x17
        do_reset();
        base[2] = 8'h10;
        valid   = 4'b0100;
        c0      = cyc;
        wait_idx("t2_accept8", 2, 8, 60);
        valid = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t2_nbeats", 32'(obs_q.size()), 32'd8);
        if (obs_q.size() > 0) check("t2_latency", 32'(obs_q[0].cyc - c0), 32'd2);
        check("t2_hold_data", 32'(cat_data), 32'h17);
        check("t2_hold_src", 32'(grp_src), 32'd2);
        check("t2_idle_flags", 32'({cat_valid, grp_last, busy}), 32'd0);
        exp_grp = '{2, 2, 0, 0, 0, 0, 0, 0};
        check_groups("t2", 0, 2, 1'b1);
        base[2] = 8'h80;

        // 3: all sources valid -> 0,1,2,3,0 rotation
        do_reset();
        valid = 4'b1111;
        wait_beats("t3_wait", 20, 200);
        valid   = 4'b0000;
        exp_grp = '{0, 1, 2, 3, 0, 0, 0, 0};
        check_groups("t3", 0, 5, 1'b1);

        // 4: source 1 stalls 3 cycles after its second word
        do_reset();
        valid = 4'b0010;
        wait_idx("t4_two", 1, 2, 40);
        valid = 4'b0000;
        @(negedge clk);
        check("t4_stall_busy", 32'(busy), 32'd1);
        check("t4_stall_ready", 32'(ready), 32'b0010);
        repeat (3) @(posedge clk);
        #1;
        valid = 4'b0010;
        wait_idx("t4_four", 1, 4, 40);
        valid = 4'b0000;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t4_nbeats", 32'(obs_q.size()), 32'd4);
        if (obs_q.size() >= 3) check("t4_gap", 32'(obs_q[2].cyc - obs_q[1].cyc), 32'd4);
        exp_grp = '{1, 0, 0, 0, 0, 0, 0, 0};
        check_groups("t4", 0, 1, 1'b0);

        // 5: mask 1010 -> only sources 1 and 3, alternating
        do_reset();
        mask  = 4'b1010;
        valid = 4'b1111;
        wait_beats("t5_wait", 16, 200);
        valid   = 4'b0000;
        exp_grp = '{1, 3, 1, 3, 0, 0, 0, 0};
        check_groups("t5", 0, 4, 1'b1);

        // 6: enable drops mid-group; group finishes, then idle; next grant is source 1
        do_reset();
        valid = 4'b1111;
        wait_idx("t6_two", 0, 2, 40);
        enable = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("t6_nbeats", 32'(obs_q.size()), 32'd4);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ready", 32'(ready), 32'd0);
        exp_grp = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_groups("t6a", 0, 1, 1'b1);
        enable = 1'b1;
        wait_beats("t6_wait", 8, 60);
        valid   = 4'b0000;
        exp_grp = '{1, 0, 0, 0, 0, 0, 0, 0};
        check_groups("t6b", 4, 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
